// File: rtl/block_sync_rx_pkg.sv
// block_sync_rx_pkg: constants and state encoding shared by the 64b/66b
// block-lock receiver and anything that drives or observes it.
// Contents: sync-header codes, counter limits, lock FSM state enum.
package block_sync_rx_pkg;

  localparam int HEAD_W = 2;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Headers per window, and invalid headers per window that force a slip.
  localparam int SH_CNT_MAX     = 64;
  localparam int SH_INVALID_MAX = 16;

  // Registered state records the outcome of the last sampled header:
  //   LOCK_INIT  - out of reset, unlocked
  //   RESET_CNT  - signal lost, unlocked, counters cleared
  //   TEST_SH    - hunting, unlocked, counting consecutive valid headers
  //   SLIP       - a slip was just requested, unlocked
  //   GOOD_64    - locked, window counters just cleared
  //   VALID_SH   - locked, last header valid
  //   INVALID_SH - locked, last header invalid (below threshold)
  typedef enum logic [2:0] {
    LOCK_INIT,
    RESET_CNT,
    TEST_SH,
    VALID_SH,
    INVALID_SH,
    GOOD_64,
    SLIP
  } state_e;

  function automatic logic sh_is_valid(input logic [1:0] head);
    return (head == SYNC_DATA) || (head == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/block_sync_rx_if.sv
// block_sync_rx_if: header stream from the aligner plus lock/slip status back.
// Ports: signal_v_i, head_i (aligner -> lock FSM); slip_v_o, lock_v_o (lock FSM -> aligner/decoder).
// No backpressure: one header per clock, slip must be honoured before the next header.
interface block_sync_rx_if #(
  parameter int HEAD_W = 2
) ();

  logic              signal_v_i;
  logic [HEAD_W-1:0] head_i;
  logic              slip_v_o;
  logic              lock_v_o;

  // Aligner / stimulus side.
  modport master (
    output signal_v_i,
    output head_i,
    input  slip_v_o,
    input  lock_v_o
  );

  // Lock FSM side.
  modport slave (
    input  signal_v_i,
    input  head_i,
    output slip_v_o,
    output lock_v_o
  );

endinterface

// File: rtl/block_sync_rx.sv
// block_sync_rx: 64b/66b block-lock FSM; judges sync headers, reports lock, asks for bit slips.
// Latency: slip_v_o is combinational in the header's cycle; lock_v_o changes at the edge that samples the deciding header.
// Backpressure: none; one header per clock. Ports: clk, nreset (sync, active-high), bus (signal_v_i, head_i, slip_v_o, lock_v_o).
module block_sync_rx
  import block_sync_rx_pkg::*;
#(
  parameter int HEAD_W = 2
) (
  input  logic                 clk,
  input  logic                 nreset,
  block_sync_rx_if.slave       bus
);

  state_e      state_q, state_d;
  logic [6:0]  sh_cnt_q, sh_cnt_d;
  logic [4:0]  sh_invalid_cnt_q, sh_invalid_cnt_d;

  logic [HEAD_W-1:0] head;
  logic              invalid_sh;
  logic              locked;
  logic [6:0]        sh_cnt_inc;
  logic [4:0]        sh_invalid_inc;
  logic              slip;

  assign head           = bus.head_i;
  assign invalid_sh     = ~sh_is_valid(head);
  assign locked         = (state_q == GOOD_64) || (state_q == VALID_SH) ||
                          (state_q == INVALID_SH);
  assign sh_cnt_inc     = sh_cnt_q + 7'd1;
  assign sh_invalid_inc = sh_invalid_cnt_q + 5'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q          <= LOCK_INIT;
      sh_cnt_q         <= '0;
      sh_invalid_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      sh_cnt_q         <= sh_cnt_d;
      sh_invalid_cnt_q <= sh_invalid_cnt_d;
    end
  end

  // Next-state logic. Loss of lock is tested before the window restart so
  // a 16th invalid header landing on the 64th slot still drops lock.
  always_comb begin
    state_d          = state_q;
    sh_cnt_d         = sh_cnt_q;
    sh_invalid_cnt_d = sh_invalid_cnt_q;
    if (!bus.signal_v_i) begin
      state_d          = RESET_CNT;
      sh_cnt_d         = '0;
      sh_invalid_cnt_d = '0;
    end else if (!locked) begin
      if (invalid_sh) begin
        state_d          = SLIP;
        sh_cnt_d         = '0;
        sh_invalid_cnt_d = '0;
      end else if (sh_cnt_inc == 7'(SH_CNT_MAX)) begin
        state_d          = GOOD_64;
        sh_cnt_d         = '0;
        sh_invalid_cnt_d = '0;
      end else begin
        state_d          = TEST_SH;
        sh_cnt_d         = sh_cnt_inc;
      end
    end else begin
      if (invalid_sh && (sh_invalid_inc == 5'(SH_INVALID_MAX))) begin
        state_d          = SLIP;
        sh_cnt_d         = '0;
        sh_invalid_cnt_d = '0;
      end else if (sh_cnt_inc == 7'(SH_CNT_MAX)) begin
        state_d          = GOOD_64;
        sh_cnt_d         = '0;
        sh_invalid_cnt_d = '0;
      end else begin
        state_d          = invalid_sh ? INVALID_SH : VALID_SH;
        sh_cnt_d         = sh_cnt_inc;
        if (invalid_sh) begin
          sh_invalid_cnt_d = sh_invalid_inc;
        end
      end
    end
  end

  // Outputs. Slip is requested for any bad header while hunting, or for the
  // bad header that would be the 16th in the current locked window.
  always_comb begin
    slip = ~nreset & bus.signal_v_i & invalid_sh &
           (~locked | (sh_invalid_cnt_q == 5'(SH_INVALID_MAX - 1)));
  end

  assign bus.slip_v_o = slip;
  assign bus.lock_v_o = locked;

endmodule

// File: tb/tb_block_sync_rx.sv
module tb_block_sync_rx;

  logic clk;
  logic nreset;

  block_sync_rx_if #(.HEAD_W(2)) bus ();

  block_sync_rx #(.HEAD_W(2)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  // Reference model state.
  bit m_lock = 1'b0;
  int m_cnt  = 0;
  int m_inv  = 0;

  // Scoreboard of expected values, pushed when stimulus is driven.
  logic sb_q[$];

  typedef struct {
    logic       rst;
    logic       sig;
    logic [1:0] head;
    logic       exp_slip;
    logic       exp_lock;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0b, expected %0b", name, cycle, act, exp);
    end
  endtask

  function automatic bit hdr_bad(input logic [1:0] h);
    return (h == 2'b00) || (h == 2'b11);
  endfunction

  function automatic logic model_slip(input logic r, input logic s, input logic [1:0] h);
    if (r || !s || !hdr_bad(h)) return 1'b0;
    if (!m_lock) return 1'b1;
    return (m_inv == 15);
  endfunction

  task automatic model_step(input logic r, input logic s, input logic [1:0] h);
    if (r || !s) begin
      m_lock = 0; m_cnt = 0; m_inv = 0;
    end else if (!m_lock) begin
      if (hdr_bad(h)) m_cnt = 0;
      else begin
        m_cnt++;
        if (m_cnt == 64) begin m_lock = 1; m_cnt = 0; m_inv = 0; end
      end
    end else begin
      m_cnt++;
      if (hdr_bad(h)) m_inv++;
      if (m_inv == 16) begin m_lock = 0; m_cnt = 0; m_inv = 0; end
      else if (m_cnt == 64) begin m_cnt = 0; m_inv = 0; end
    end
  endtask

  // One header cycle. Called just after a rising edge; returns the slip seen
  // mid-cycle and the lock seen just after the next rising edge.
  task automatic cyc(input logic r, input logic s, input logic [1:0] h,
                     output logic slip_seen, output logic lock_seen);
    nreset         = r;
    bus.signal_v_i = s;
    bus.head_i     = h;
    sb_q.push_back(model_slip(r, s, h));
    @(negedge clk);
    slip_seen = bus.slip_v_o;
    check("slip", slip_seen, sb_q.pop_front());
    model_step(r, s, h);
    sb_q.push_back(m_lock);
    @(posedge clk);
    #1;
    cycle++;
    lock_seen = bus.lock_v_o;
    check("lock", lock_seen, sb_q.pop_front());
  endtask

  function automatic logic [1:0] rnd_valid();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] rnd_bad();
    return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic acquire(output logic sl, output logic lk);
    for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, rnd_valid(), sl, lk);
  endtask

  logic sl, lk;
  logic any_slip;
  int   guard;

  initial begin
    nreset         = 1'b1;
    bus.signal_v_i = 1'b0;
    bus.head_i     = 2'b00;
    @(posedge clk);
    #1;

    // Basic vectors with fixed expectations.
    vecs.push_back('{1'b1, 1'b1, 2'b00, 1'b0, 1'b0});  // reset masks slip
    vecs.push_back('{1'b0, 1'b1, 2'b00, 1'b1, 1'b0});  // hunting, bad -> slip
    vecs.push_back('{1'b0, 1'b1, 2'b11, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 1'b0});  // no signal, no slip
    vecs.push_back('{1'b0, 1'b0, 2'b11, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b11, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b11, 1'b1, 1'b0});
    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].sig, vecs[i].head, sl, lk);
      check("vec_slip", sl, vecs[i].exp_slip);
      check("vec_lock", lk, vecs[i].exp_lock);
    end

    // Acquire lock: 63 valid headers not enough, 64th locks.
    cyc(1'b1, 1'b1, 2'b01, sl, lk);
    any_slip = 1'b0;
    for (int i = 0; i < 63; i++) begin
      cyc(1'b0, 1'b1, rnd_valid(), sl, lk);
      any_slip |= sl;
    end
    check("acq_63_unlocked", lk, 1'b0);
    cyc(1'b0, 1'b1, rnd_valid(), sl, lk);
    any_slip |= sl;
    check("acq_64_locked", lk, 1'b1);
    check("acq_no_slip", any_slip, 1'b0);

    // Window hold: 15 bad + 49 good per window, three windows.
    any_slip = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 64; i++) begin
        cyc(1'b0, 1'b1, (i < 60 && (i % 4) == 0) ? rnd_bad() : rnd_valid(), sl, lk);
        any_slip |= sl;
      end
    end
    check("hold_locked", lk, 1'b1);
    check("hold_no_slip", any_slip, 1'b0);

    // Window tie: 48 good then 16 bad; the 64th header is the 16th bad.
    for (int i = 0; i < 48; i++) cyc(1'b0, 1'b1, rnd_valid(), sl, lk);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, rnd_bad(), sl, lk);
    check("tie_15_no_slip", sl, 1'b0);
    check("tie_15_locked", lk, 1'b1);
    cyc(1'b0, 1'b1, rnd_bad(), sl, lk);
    check("tie_16_slip", sl, 1'b1);
    check("tie_16_unlocked", lk, 1'b0);

    // Lose lock under random headers.
    acquire(sl, lk);
    check("relock", lk, 1'b1);
    guard = 0;
    while (m_lock && guard < 1000) begin
      cyc(1'b0, 1'b1, 2'($urandom_range(0, 3)), sl, lk);
      guard++;
    end
    check("lose_lock", lk, 1'b0);

    // Hunting: 150 random headers while unlocked.
    for (int i = 0; i < 150; i++) cyc(1'b0, 1'b1, 2'($urandom_range(0, 3)), sl, lk);

    // Signal loss while locked, then recovery.
    cyc(1'b1, 1'b1, 2'b01, sl, lk);
    acquire(sl, lk);
    check("pre_loss_locked", lk, 1'b1);
    any_slip = 1'b0;
    for (int i = 0; i < 70; i++) begin
      cyc(1'b0, 1'b0, (i % 3 == 0) ? rnd_bad() : rnd_valid(), sl, lk);
      any_slip |= sl;
    end
    check("loss_unlocked", lk, 1'b0);
    check("loss_no_slip", any_slip, 1'b0);
    acquire(sl, lk);
    check("recover_locked", lk, 1'b1);

    // Reset mid-lock during a bad header.
    cyc(1'b1, 1'b1, 2'b00, sl, lk);
    check("rst_no_slip", sl, 1'b0);
    check("rst_unlocked", lk, 1'b0);
    cyc(1'b0, 1'b1, 2'b00, sl, lk);
    check("post_rst_slip", sl, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
